// File: rtl/down_timer.sv
// down_timer: loadable down-counting timer with one-shot and periodic modes.
// A producer loads a start value through a valid/ready handshake. While RUN and
// enabled the count decrements; reaching terminal count raises a one-cycle
// tc_pulse and either expires (one-shot) or reloads (periodic).
module down_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             periodic_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_pulse_o,
  output logic             running_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_EXPIRED = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             tc_q, tc_d;
  logic             load_ok;

  // Loads are refused during clear and while actively counting, so a load can
  // never race a decrement or a terminal count.
  assign load_ok = load_valid_i && !clear_i && (state_q != S_RUN || !enable_i);

  // State and datapath registers, asynchronously reset to an idle, empty timer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      count_q  <= ZERO;
      reload_q <= ZERO;
      mode_q   <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      tc_q     <= tc_d;
    end
  end

  // Next-state logic: clear beats load, load beats counting; tc is a strobe.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    tc_d     = 1'b0;

    if (clear_i) begin
      // Abort: reload value and mode survive so software can inspect them.
      state_d = S_IDLE;
      count_d = ZERO;
    end else if (load_ok) begin
      count_d  = load_value_i;
      reload_d = load_value_i;
      mode_d   = periodic_i;
      if (load_value_i != ZERO) begin
        state_d = S_RUN;
      end else begin
        // A zero load terminates immediately; a zero period is meaningless,
        // so periodic mode parks in IDLE instead of expiring.
        tc_d    = 1'b1;
        state_d = periodic_i ? S_IDLE : S_EXPIRED;
      end
    end else if (state_q == S_RUN && enable_i) begin
      if (count_q == ONE) begin
        tc_d = 1'b1;
        if (mode_q) begin
          count_d = reload_q;
        end else begin
          count_d = ZERO;
          state_d = S_EXPIRED;
        end
      end else if (count_q != ZERO) begin
        count_d = count_q - ONE;
      end else begin
        // RUN with a zero count is unreachable; recover rather than underflow.
        state_d = S_IDLE;
      end
    end
  end

  // Output decode: status flags come straight from the state register.
  always_comb begin
    load_ready_o = !clear_i && (state_q != S_RUN || !enable_i);
    running_o    = (state_q == S_RUN);
    done_o       = (state_q == S_EXPIRED);
    count_o      = count_q;
    tc_pulse_o   = tc_q;
  end

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
Loadable down-counting timer. It is the complement of the team's free-running up-counter. A producer loads a start value through a valid/ready handshake. The block counts down on enable and flags terminal count, either once (one-shot) or repeatedly from a stored reload value (periodic). It sits beside the up-counter in the timing subsystem and drives timeouts and periodic ticks.

Parameters:
WIDTH, 8, bit width of count, load value and reload register.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset; low = in reset.
enable  input  1  count enable; 0 = pause and hold count.
clear  input  1  synchronous abort to IDLE.
load_valid  input  1  load request.
load_ready  output  1  block can accept a load this cycle.
load_value  input  WIDTH  start/reload value, sampled on handshake.
periodic  input  1  mode, sampled on handshake: 1 = periodic, 0 = one-shot.
count  output  WIDTH  current count, registered.
tc_pulse  output  1  one-cycle terminal-count strobe, registered.
running  output  1  high while state is RUN.
done  output  1  high while state is EXPIRED (one-shot finished).

Behaviour:
- Reset (reset low, asynchronous): state IDLE, count=0, reload register=0, mode register=0, tc_pulse=0, running=0, done=0. Release is synchronous to clk; the first action is possible on the first rising edge after release.
- States are IDLE, RUN and EXPIRED. running and done decode state directly from registers.
- load_ready (combinational) = !clear && (state!=RUN || enable==0). Loads are accepted in IDLE, in EXPIRED, and in RUN only while paused.
- Handshake: a load is accepted on an edge where load_valid && load_ready.
  - count<=load_value, reload<=load_value, mode<=periodic.
  - If load_value!=0, next state is RUN.
  - If load_value==0, next state is EXPIRED when mode is one-shot. In periodic mode a zero load goes to IDLE instead (zero period is illegal). In both cases tc_pulse<=1.
- Latency: count shows load_value in the cycle after acceptance. The first decrement occurs on the following edge if enable=1.
- RUN, enable=1, count>1: count<=count-1.
- RUN, enable=1, count==1:
  - Periodic: count<=reload, tc_pulse<=1, stay in RUN.
  - One-shot: count<=0, tc_pulse<=1, go to EXPIRED.
- Period: with constant enable and load L≥1, tc_pulse is high exactly once every L cycles. The first pulse is registered on the L-th edge after the load edge. L=1 gives tc_pulse continuously high in periodic mode.
- RUN, enable=0: count and state hold; tc_pulse<=0.
- tc_pulse defaults to 0 on every edge not listed above.
- EXPIRED: count holds 0 and done=1 until clear or a new load.
- clear=1 on an edge (not in reset): state IDLE, count=0, tc_pulse=0. Reload and mode registers are kept.
  - clear has priority over load; load_ready is 0 so no load is accepted.
  - clear has priority over terminal count; no tc_pulse is produced.
- Load while paused in RUN replaces count, reload and mode. Any pending terminal count is discarded.
- No wrap-around: count never decrements below 0 and never underflows to all-ones.
- Reset asserted mid-count forces reset values immediately, without waiting for clk.
- enable is ignored in IDLE and EXPIRED.

Test Plan:
1. Reset low for 2 cycles, then release. Check count=0, tc_pulse=0, running=0, done=0, load_ready=1. Then pull reset low mid-RUN between edges: outputs clear before the next edge.
2. One-shot: load 5 with periodic=0 and enable=1. count reads 5,4,3,2,1,0. tc_pulse is high for exactly one cycle, coincident with count=0. done=1 afterwards and count stays 0 for 20 cycles.
3. Periodic: load 4 with periodic=1 and enable=1 for 40 cycles. Expect exactly 10 tc_pulse cycles spaced 4 apart; count cycles 4,3,2,1,4,... Load 1 gives tc_pulse high every cycle.
4. Pause/reload: load 10, run 3 cycles (count=7), drop enable for 5 cycles. count holds 7 and load_ready=1. Load 3 while paused, then count 3,2,1,0 with tc_pulse once.
5. Priority: in RUN with count=1, enable=1, assert clear and load_valid with value 9. Expect state IDLE, count=0, no tc_pulse, load_ready=0 during that cycle, and the load is not taken.
6. Zero load: load 0 one-shot gives tc_pulse=1 next cycle and done=1. Load 0 periodic gives tc_pulse=1, state IDLE, running=0.
